// File: rtl/ddrif_hzz_arb.sv
// Round-robin arbiter granting one of NREQ HZZ requesters access to a shared slave port.
// Tracks each transaction as command, write-data and response phases, counting beats from the command's len field.
module ddrif_hzz_arb #(
    parameter int HZZ_DW = 256,
    parameter int NREQ   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    input  logic [NREQ*HZZ_DW-1:0]   m_mosi,
    input  logic [NREQ-1:0]          m_mosi_valid,
    output logic [HZZ_DW-1:0]        m_miso,
    output logic [NREQ-1:0]          m_miso_valid,
    output logic [HZZ_DW-1:0]        s_mosi,
    output logic                     s_mosi_valid,
    input  logic [HZZ_DW-1:0]        s_miso,
    input  logic                     s_miso_valid,
    output logic                     idle,
    output logic                     err_unexp
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WDAT = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]     g_q, g_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [HZZ_DW-1:0] s_mosi_q, s_mosi_d;
    logic              s_mosi_valid_q, s_mosi_valid_d;
    logic [HZZ_DW-1:0] m_miso_q, m_miso_d;
    logic [NREQ-1:0]   m_miso_valid_q, m_miso_valid_d;
    logic              err_q, err_d;

    logic [HZZ_DW-1:0] g_beat;
    logic              g_valid;
    logic              fwd;
    logic              cmd_wr;
    logic [7:0]        cmd_len;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     scan_idx;

    always_comb begin
        g_beat  = m_mosi[32'(g_q) * HZZ_DW +: HZZ_DW];
        g_valid = m_mosi_valid[g_q];
        fwd     = g_valid && ((state_q == S_CMD) || (state_q == S_WDAT));
        cmd_wr  = g_beat[HZZ_DW-1];
        cmd_len = g_beat[HZZ_DW-3 -: 8];
    end

    // First requesting index at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PW'((32'(rr_ptr_q) + k) % NREQ);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        g_d            = g_q;
        rr_ptr_d       = rr_ptr_q;
        cnt_d          = cnt_q;
        s_mosi_d       = s_mosi_q;
        s_mosi_valid_d = fwd;
        m_miso_d       = m_miso_q;
        m_miso_valid_d = '0;
        err_d          = err_q | (s_miso_valid && (state_q != S_RSP));

        if (fwd) begin
            s_mosi_d = g_beat;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    g_d             = pick_idx;
                    state_d         = S_CMD;
                end
            end
            S_CMD: begin
                if (g_valid) begin
                    cnt_d   = {1'b0, cmd_len} + 9'd1;
                    state_d = cmd_wr ? S_WDAT : S_RSP;
                end
            end
            S_WDAT: begin
                if (g_valid) begin
                    if (cnt_q <= 9'd1) begin
                        cnt_d   = 9'd1;
                        state_d = S_RSP;
                    end else begin
                        cnt_d = cnt_q - 9'd1;
                    end
                end
            end
            default: begin
                if (s_miso_valid) begin
                    m_miso_d       = s_miso;
                    m_miso_valid_d = gnt_q;
                    if (cnt_q <= 9'd1) begin
                        cnt_d    = '0;
                        gnt_d    = '0;
                        state_d  = S_IDLE;
                        rr_ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 9'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            gnt_q          <= '0;
            g_q            <= '0;
            rr_ptr_q       <= '0;
            cnt_q          <= '0;
            s_mosi_q       <= '0;
            s_mosi_valid_q <= 1'b0;
            m_miso_q       <= '0;
            m_miso_valid_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            g_q            <= g_d;
            rr_ptr_q       <= rr_ptr_d;
            cnt_q          <= cnt_d;
            s_mosi_q       <= s_mosi_d;
            s_mosi_valid_q <= s_mosi_valid_d;
            m_miso_q       <= m_miso_d;
            m_miso_valid_q <= m_miso_valid_d;
            err_q          <= err_d;
        end
    end

    assign gnt          = gnt_q;
    assign s_mosi       = s_mosi_q;
    assign s_mosi_valid = s_mosi_valid_q;
    assign m_miso       = m_miso_q;
    assign m_miso_valid = m_miso_valid_q;
    assign err_unexp    = err_q;
    assign idle         = (state_q == S_IDLE);

endmodule

// File: tb/tb_ddrif_hzz_arb.sv
// Directed bench for ddrif_hzz_arb: stimulus pushes expected slave and response beats into queues,
// a negedge monitor pops and compares them whenever the DUT presents a valid beat.
module tb_ddrif_hzz_arb;

    localparam int DW = 16;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     gnt;
    logic [NR*DW-1:0]  m_mosi;
    logic [NR-1:0]     m_mosi_valid;
    logic [DW-1:0]     m_miso;
    logic [NR-1:0]     m_miso_valid;
    logic [DW-1:0]     s_mosi;
    logic              s_mosi_valid;
    logic [DW-1:0]     s_miso;
    logic              s_miso_valid;
    logic              idle;
    logic              err_unexp;

    ddrif_hzz_arb #(
        .HZZ_DW(DW),
        .NREQ  (NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .m_mosi      (m_mosi),
        .m_mosi_valid(m_mosi_valid),
        .m_miso      (m_miso),
        .m_miso_valid(m_miso_valid),
        .s_mosi      (s_mosi),
        .s_mosi_valid(s_mosi_valid),
        .s_miso      (s_miso),
        .s_miso_valid(s_miso_valid),
        .idle        (idle),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    s_q[$];
    logic [NR+DW-1:0] r_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every beat the DUT presents must match the head of its queue.
    initial begin
        logic [DW-1:0]    es;
        logic [NR+DW-1:0] er;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (s_mosi_valid) begin
                    if (s_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL s_mosi_unexpected: got beat %h with nothing expected", s_mosi);
                    end else begin
                        es = s_q.pop_front();
                        check("s_mosi", 32'(s_mosi), 32'(es));
                    end
                end
                if (m_miso_valid != '0) begin
                    if (r_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL m_miso_unexpected: got valid %b data %h with nothing expected",
                                 m_miso_valid, m_miso);
                    end else begin
                        er = r_q.pop_front();
                        check("m_miso", 32'(m_miso), 32'(er[DW-1:0]));
                        check("m_miso_valid", 32'(m_miso_valid), 32'(er[NR+DW-1:DW]));
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] cmd(input logic wr, input logic [7:0] len);
        return {wr, 1'b0, len, 6'h00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of requester beats; only the granted requester's beat is expected at the slave.
    task automatic send2(input logic [DW-1:0] d0, input logic v0,
                         input logic [DW-1:0] d1, input logic v1, input int g);
        tick();
        s_miso_valid    = 1'b0;
        m_mosi          = {d1, d0};
        m_mosi_valid    = {v1, v0};
        if (g == 0 && v0) s_q.push_back(d0);
        if (g == 1 && v1) s_q.push_back(d1);
    endtask

    task automatic rsp(input logic [DW-1:0] d, input logic [NR-1:0] vec);
        tick();
        m_mosi_valid = '0;
        s_miso       = d;
        s_miso_valid = 1'b1;
        r_q.push_back({vec, d});
    endtask

    task automatic quiet();
        tick();
        m_mosi_valid = '0;
        s_miso_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},          32'(gnt), 32'd0);
        check({tag, "_m_miso_valid"}, 32'(m_miso_valid), 32'd0);
        check({tag, "_m_miso"},       32'(m_miso), 32'd0);
        check({tag, "_s_mosi"},       32'(s_mosi), 32'd0);
        check({tag, "_s_mosi_valid"}, 32'(s_mosi_valid), 32'd0);
        check({tag, "_err_unexp"},    32'(err_unexp), 32'd0);
        check({tag, "_idle"},         32'(idle), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        req          = '0;
        m_mosi       = '0;
        m_mosi_valid = '0;
        s_miso       = '0;
        s_miso_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        // Both request; requester 0 wins, writes len=3 while requester 1 drives junk beats.
        tick();
        req = 2'b11;
        @(negedge clk);
        check("gnt_before", 32'(gnt), 32'd0);
        send2(cmd(1'b1, 8'd3), 1'b1, 16'h5a5a, 1'b1, 0);
        @(negedge clk);
        check("gnt_first", 32'(gnt), 32'b01);
        req = 2'b10;
        send2(16'h0101, 1'b1, 16'hdead, 1'b1, 0);
        send2(16'h0202, 1'b1, 16'hbeef, 1'b1, 0);
        send2(16'h0303, 1'b1, 16'h0000, 1'b0, 0);
        send2(16'h0404, 1'b1, 16'hcafe, 1'b1, 0);
        rsp(16'hac01, 2'b01);
        quiet();
        @(negedge clk);
        check("idle_after_wr", 32'(idle), 32'd1);
        check("gnt_drop_wr", 32'(gnt), 32'd0);

        // Requester 1 is next in round-robin order: read len=7.
        send2(16'h0000, 1'b0, cmd(1'b0, 8'd7), 1'b1, 1);
        @(negedge clk);
        check("gnt_second", 32'(gnt), 32'b10);
        req = 2'b00;
        for (int i = 0; i < 8; i++) rsp(16'h1000 + 16'(i), 2'b10);
        quiet();
        @(negedge clk);
        check("gnt_drop_rd", 32'(gnt), 32'd0);
        check("idle_after_rd", 32'(idle), 32'd1);
        quiet();
        quiet();
        @(negedge clk);
        check("m_miso_hold", 32'(m_miso), 32'h1007);

        // Response beat while idle: dropped and flagged.
        tick();
        s_miso       = 16'hbad0;
        s_miso_valid = 1'b1;
        quiet();
        @(negedge clk);
        check("err_set", 32'(err_unexp), 32'd1);
        repeat (3) quiet();
        @(negedge clk);
        check("err_sticky", 32'(err_unexp), 32'd1);

        // len=255 write interrupted by reset during WDAT.
        tick();
        req = 2'b01;
        send2(cmd(1'b1, 8'd255), 1'b1, 16'h0000, 1'b0, 0);
        @(negedge clk);
        check("gnt_long", 32'(gnt), 32'b01);
        req = 2'b00;
        for (int i = 0; i < 10; i++) send2(16'h2000 + 16'(i), 1'b1, 16'h0000, 1'b0, 0);
        tick();
        rst_n        = 1'b0;
        m_mosi_valid = '0;
        s_q.delete();
        #1;
        check_reset("midrst");
        repeat (2) tick();
        rst_n = 1'b1;

        // Fresh read after release: rr_ptr back at 0.
        tick();
        req = 2'b01;
        send2(cmd(1'b0, 8'd1), 1'b1, 16'h0000, 1'b0, 0);
        @(negedge clk);
        check("gnt_after_rst", 32'(gnt), 32'b01);
        req = 2'b00;
        rsp(16'h3131, 2'b01);
        rsp(16'h3232, 2'b01);
        quiet();
        @(negedge clk);
        check("idle_final", 32'(idle), 32'd1);
        check("gnt_final", 32'(gnt), 32'd0);
        check("err_final", 32'(err_unexp), 32'd0);

        repeat (3) quiet();
        @(negedge clk);
        check("s_q_drained", 32'(s_q.size()), 32'd0);
        check("r_q_drained", 32'(r_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
